// File: rtl/universal_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_engine
// Purpose  : WIDTH-bit universal shift register with single-step and counted
//            multi-cycle operation (busy/done handshake).
//            Define SHREG_ROTATE_EN to enable the ROR/ROL codes.
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] inShift,
    input  logic [2:0]       select,
    input  logic             serialIn,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] outShift,
    output logic             serialOut,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] c_HOLD  = 3'b000;
    localparam logic [2:0] c_LOAD  = 3'b001;
    localparam logic [2:0] c_SRL   = 3'b010;
    localparam logic [2:0] c_SLL   = 3'b011;
    localparam logic [2:0] c_SRA   = 3'b100;
`ifdef SHREG_ROTATE_EN
    localparam logic [2:0] c_ROR   = 3'b101;
    localparam logic [2:0] c_ROL   = 3'b110;
`endif
    localparam logic [2:0] c_CLEAR = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_reg;
    logic             r_so;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_next_reg;
    logic             w_next_so;
    logic             w_is_step;

    // While running, the latched opcode drives the datapath, not the live select.
    assign w_op = (r_state == S_RUN) ? r_op : select;

    always_comb begin
        w_next_reg = r_reg;
        w_next_so  = r_so;
        case (w_op)
            c_LOAD:  w_next_reg = inShift;
            c_SRL:   {w_next_reg, w_next_so} = {serialIn, r_reg};
            c_SLL:   {w_next_so, w_next_reg} = {r_reg, serialIn};
            c_SRA:   {w_next_reg, w_next_so} = {r_reg[WIDTH-1], r_reg};
`ifdef SHREG_ROTATE_EN
            c_ROR:   {w_next_reg, w_next_so} = {r_reg[0], r_reg};
            c_ROL:   {w_next_so, w_next_reg} = {r_reg, r_reg[WIDTH-1]};
`endif
            c_CLEAR: begin
                w_next_reg = '0;
                w_next_so  = 1'b0;
            end
            default: begin
                w_next_reg = r_reg;
                w_next_so  = r_so;
            end
        endcase
    end

    always_comb begin
        w_is_step = 1'b0;
        case (select)
            c_SRL, c_SLL, c_SRA: w_is_step = 1'b1;
`ifdef SHREG_ROTATE_EN
            c_ROR, c_ROL:        w_is_step = 1'b1;
`endif
            default:             w_is_step = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= c_HOLD;
            r_cnt   <= '0;
            r_reg   <= '0;
            r_so    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_step && (amount != '0)) begin
                            r_op    <= select;
                            r_cnt   <= amount;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            // Non-counted start: one execution, or none for a zero count.
                            if (amount != '0) begin
                                r_reg <= w_next_reg;
                                r_so  <= w_next_so;
                            end
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_reg <= w_next_reg;
                        r_so  <= w_next_so;
                    end
                end
                S_RUN: begin
                    r_reg <= w_next_reg;
                    r_so  <= w_next_so;
                    r_cnt <= r_cnt - AMT_W'(1);
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign outShift  = r_reg;
    assign serialOut = r_so;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_engine
// Purpose  : Self-checking bench for universal_shift_engine (WIDTH=8, AMT_W=4)
//            against a closed-form arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_engine;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] inShift = '0;
    logic [2:0] select = '0;
    logic       serialIn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] amount = '0;
    logic [7:0] outShift;
    logic       serialOut;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;

    universal_shift_engine #(.WIDTH(8), .AMT_W(4)) dut (
        .clock(clock), .reset(reset), .inShift(inShift), .select(select),
        .serialIn(serialIn), .start(start), .amount(amount),
        .outShift(outShift), .serialOut(serialOut), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Result of n consecutive steps of op on v with a constant fill bit s.
    function automatic void model_steps(input logic [2:0] op, input logic [7:0] v,
                                        input logic s, input int n,
                                        output logic [7:0] res, output logic so);
        logic [23:0]       ext, t, t2;
        logic signed [7:0] sv, st, st2;
        logic [15:0]       dbl, d;
        int                r;
        res = v;
        so  = 1'b0;
        dbl = {v, v};
        r   = n % 8;
        case (op)
            3'd2: begin
                ext = {{16{s}}, v};
                t   = ext >> n;
                res = t[7:0];
                so  = ext[n-1];
            end
            3'd3: begin
                ext = {v, {16{s}}};
                t   = ext << n;
                t2  = ext << (n - 1);
                res = t[23:16];
                so  = t2[23];
            end
            3'd4: begin
                sv  = v;
                st  = sv >>> n;
                st2 = sv >>> (n - 1);
                res = st;
                so  = st2[0];
            end
            3'd5: begin
                d   = dbl >> r;
                res = d[7:0];
                so  = res[7];
            end
            3'd6: begin
                d   = dbl << r;
                res = d[15:8];
                so  = res[0];
            end
            default: res = v;
        endcase
    endfunction

    task automatic load(input logic [7:0] v);
        select = 3'd1; inShift = v; start = 1'b0;
        tick();
        select = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (outShift !== 8'h00) $display("FAIL reset_out got %h want 00", outShift); else passed++;
        total++; if (serialOut !== 1'b0) $display("FAIL reset_so got %b want 0", serialOut); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    endtask

    task automatic test_load_srl();
        load(8'hB5);
        total++; if (outShift !== 8'hB5) $display("FAIL load got %h want b5", outShift); else passed++;
        select = 3'd2; serialIn = 1'b1;
        tick();
        select = 3'd0;
        total++; if (outShift !== 8'hDA) $display("FAIL srl_out got %h want da", outShift); else passed++;
        total++; if (serialOut !== 1'b1) $display("FAIL srl_so got %b want 1", serialOut); else passed++;
    endtask

    task automatic test_sra_counted();
        load(8'h96);
        select = 3'd4; amount = 4'd3; start = 1'b1;
        tick();
        total++; if (busy !== 1'b1 || done !== 1'b0 || outShift !== 8'h96)
            $display("FAIL sra_start busy=%b done=%b out=%h want 1 0 96", busy, done, outShift); else passed++;
        for (int i = 0; i < 3; i++) begin
            start = ~start; select = 3'($urandom); inShift = 8'($urandom); amount = 4'($urandom);
            tick();
            if (i < 2) begin
                total++; if (busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL sra_busy%0d busy=%b done=%b want 1 0", i, busy, done); else passed++;
            end
        end
        start = 1'b0; select = 3'd0;
        total++; if (busy !== 1'b0 || done !== 1'b1)
            $display("FAIL sra_done busy=%b done=%b want 0 1", busy, done); else passed++;
        total++; if (outShift !== 8'hF2 || serialOut !== 1'b1)
            $display("FAIL sra_result got %h/%b want f2/1", outShift, serialOut); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL sra_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_rotate();
        int edges;
        load(8'h81);
        select = 3'd6; amount = 4'd4; start = 1'b1;
        tick();
        start = 1'b0; select = 3'd0;
`ifdef SHREG_ROTATE_EN
        edges = 1;
        total++; if (busy !== 1'b1) $display("FAIL rol_busy got %b want 1", busy); else passed++;
        while (done !== 1'b1 && edges < 12) begin
            tick();
            edges++;
        end
        total++; if (edges !== 5) $display("FAIL rol_latency got %0d want 5", edges); else passed++;
        total++; if (outShift !== 8'h18 || serialOut !== 1'b0)
            $display("FAIL rol_result got %h/%b want 18/0", outShift, serialOut); else passed++;
`else
        edges = 0;
        total++; if (busy !== 1'b0 || done !== 1'b1)
            $display("FAIL rol_off busy=%b done=%b want 0 1", busy, done); else passed++;
        total++; if (outShift !== 8'h81) $display("FAIL rol_off_out got %h want 81", outShift); else passed++;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rol_off_after busy=%b done=%b want 0 0 (edges %0d)", busy, done, edges); else passed++;
`endif
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        load(8'hFF);
        select = 3'd3; amount = 4'd10; serialIn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; select = 3'd0;
        tick();
        total++; if (busy !== 1'b1 || outShift !== 8'hFE)
            $display("FAIL midrun busy=%b out=%h want 1 fe", busy, outShift); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (outShift !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrun_reset out=%h busy=%b done=%b want 00 0 0", outShift, busy, done); else passed++;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) $display("FAIL midrun_no_done got %b want 0", saw_done); else passed++;
    endtask

    task automatic test_back_to_back();
        load(8'h3C);
        select = 3'd2; amount = 4'd0; start = 1'b1;
        tick();
        total++; if (outShift !== 8'h3C || busy !== 1'b0 || done !== 1'b1)
            $display("FAIL zero_amt out=%h busy=%b done=%b want 3c 0 1", outShift, busy, done); else passed++;
        select = 3'd3; amount = 4'd2; serialIn = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; select = 3'd0;
        total++; if (busy !== 1'b1 || done !== 1'b0 || outShift !== 8'h3C)
            $display("FAIL b2b_start busy=%b done=%b out=%h want 1 0 3c", busy, done, outShift); else passed++;
        tick(); tick();
        total++; if (done !== 1'b1 || busy !== 1'b0 || outShift !== 8'hF3 || serialOut !== 1'b0)
            $display("FAIL b2b_result done=%b busy=%b out=%h so=%b want 1 0 f3 0",
                     done, busy, outShift, serialOut); else passed++;
        tick();
    endtask

    task automatic test_random_counted();
        logic [7:0] v, exp_r;
        logic [2:0] op;
        logic       s, exp_s, overlap;
        int         n, edges, busy_cyc;
        for (int it = 0; it < 16; it++) begin
            v = 8'($urandom);
            n = $urandom_range(15, 1);
            s = 1'($urandom);
`ifdef SHREG_ROTATE_EN
            op = 3'($urandom_range(6, 2));
`else
            op = 3'($urandom_range(4, 2));
`endif
            load(v);
            select = op; amount = 4'(n); serialIn = s; start = 1'b1;
            tick();
            start = 1'($urandom); select = 3'($urandom); amount = 4'($urandom); inShift = 8'($urandom);
            edges = 1; busy_cyc = 0; overlap = 1'b0;
            while (done !== 1'b1 && edges < 20) begin
                if (busy === 1'b1) busy_cyc++;
                tick();
                edges++;
                if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
            end
            start = 1'b0; select = 3'd0;
            model_steps(op, v, s, n, exp_r, exp_s);
            total++; if (edges !== n + 1 || busy_cyc !== n || overlap !== 1'b0)
                $display("FAIL rnd_timing op=%0d n=%0d edges=%0d busy=%0d ovl=%b want edges %0d busy %0d",
                         op, n, edges, busy_cyc, overlap, n + 1, n); else passed++;
            total++; if (outShift !== exp_r || serialOut !== exp_s)
                $display("FAIL rnd_result op=%0d v=%h n=%0d s=%b got %h/%b want %h/%b",
                         op, v, n, s, outShift, serialOut, exp_r, exp_s); else passed++;
            tick();
        end
    endtask

    task automatic test_random_single();
        logic [7:0] exp_r, d, r;
        logic       exp_s, so;
        logic [2:0] op;
        select = 3'd7; start = 1'b0;
        tick();
        exp_r = 8'h00; exp_s = 1'b0;
        for (int it = 0; it < 24; it++) begin
            op = 3'($urandom);
            d  = 8'($urandom);
            select = op; inShift = d; serialIn = 1'($urandom); start = 1'b0;
            case (op)
                3'd0: ;
                3'd1: exp_r = d;
                3'd7: begin exp_r = 8'h00; exp_s = 1'b0; end
`ifndef SHREG_ROTATE_EN
                3'd5, 3'd6: ;
`endif
                default: begin
                    model_steps(op, exp_r, serialIn, 1, r, so);
                    exp_r = r; exp_s = so;
                end
            endcase
            tick();
            total++; if (outShift !== exp_r || serialOut !== exp_s || busy !== 1'b0 || done !== 1'b0)
                $display("FAIL single op=%0d got %h/%b b%b d%b want %h/%b 0 0",
                         op, outShift, serialOut, busy, done, exp_r, exp_s); else passed++;
        end
        select = 3'd0;
    endtask

    initial begin
        test_reset();
        test_load_srl();
        test_sra_counted();
        test_rotate();
        test_reset_mid_run();
        test_back_to_back();
        test_random_counted();
        test_random_single();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
